// File: rtl/ascii_word_packer.sv
// ascii_word_packer: packs accepted ASCII bytes little-endian into 32-bit words with keep/last, counts uppercase, flags lowercase
module ascii_word_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_ascii_in,
  input  logic             i_in_valid,
  input  logic             i_in_last,
  output logic             o_in_ready,
  output logic [31:0]      o_word_out,
  output logic [3:0]       o_word_keep,
  output logic             o_word_last,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic [CNT_W-1:0] o_upper_count,
  output logic             o_lower_err
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_lane [4];
  logic [3:0] r_keep;
  logic [1:0] r_idx;
  logic       r_last;
  logic       w_accept;
  logic       w_close;
  logic       w_upper;
  logic       w_lower;
  assign w_accept = i_in_valid && o_in_ready;
  assign w_close  = i_in_last || (i_ascii_in == 8'h00);
  assign w_upper  = (i_ascii_in >= 8'h41) && (i_ascii_in <= 8'h5A);
  assign w_lower  = (i_ascii_in >= 8'h61) && (i_ascii_in <= 8'h7A);
  assign o_word_out  = {r_lane[3], r_lane[2], r_lane[1], r_lane[0]};
  assign o_word_keep = r_keep;
  assign o_word_last = r_last;
  // state register
  always_ff @(posedge clk)
    if (!rst_n) r_state <= FILL;
    else r_state <= w_next;
  // next state: close the word on the fourth byte or a string terminator, release on word_ready
  always_comb
    w_next = (r_state == FILL) ? ((w_accept && (r_idx == 2'd3 || w_close)) ? HOLD : FILL)
                               : (i_word_ready ? FILL : HOLD);
  // handshake outputs depend only on state and reset
  always_comb begin
    o_in_ready   = rst_n && (r_state == FILL);
    o_word_valid = (r_state == HOLD);
  end
  // lane fill and clear after the held word is taken
  always_ff @(posedge clk)
    if (!rst_n || (r_state == HOLD && i_word_ready)) begin
      r_lane <= '{default: 8'h00};
      r_keep <= 4'h0;
      r_idx  <= 2'd0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_lane[r_idx] <= i_ascii_in;
      r_keep[r_idx] <= 1'b1;
      r_idx         <= r_idx + 2'd1;
      if (w_close) r_last <= 1'b1;
    end
  // saturating uppercase counter and sticky lowercase flag
  always_ff @(posedge clk)
    if (!rst_n) begin
      o_upper_count <= '0;
      o_lower_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_upper && o_upper_count != '1) o_upper_count <= o_upper_count + 1'b1;
      if (w_lower) o_lower_err <= 1'b1;
    end
endmodule

// File: tb/tb_ascii_word_packer.sv
// tb_ascii_word_packer: directed self-checking bench for ascii_word_packer
module tb_ascii_word_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        word_ready = 1'b0;
  logic        in_ready, word_last, word_valid, lower_err;
  logic [31:0] word_out;
  logic [3:0]  word_keep, upper_count;
  logic        in_ready16, word_last16, word_valid16, lower_err16;
  logic [31:0] word_out16;
  logic [3:0]  word_keep16;
  logic [15:0] upper_count16;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  ascii_word_packer #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_ascii_in(din), .i_in_valid(valid), .i_in_last(last),
    .o_in_ready(in_ready), .o_word_out(word_out), .o_word_keep(word_keep), .o_word_last(word_last),
    .o_word_valid(word_valid), .i_word_ready(word_ready), .o_upper_count(upper_count), .o_lower_err(lower_err)
  );
  ascii_word_packer dut16 (
    .clk(clk), .rst_n(rst_n), .i_ascii_in(din), .i_in_valid(valid), .i_in_last(last),
    .o_in_ready(in_ready16), .o_word_out(word_out16), .o_word_keep(word_keep16), .o_word_last(word_last16),
    .o_word_valid(word_valid16), .i_word_ready(word_ready), .o_upper_count(upper_count16), .o_lower_err(lower_err16)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    word_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic put(input logic [7:0] b, input logic l);
    int n = 0;
    @(negedge clk);
    valid = 1'b1;
    din = b;
    last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("put_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    last = 1'b0;
  endtask
  task automatic get(input string tag, input logic [31:0] w, input logic [3:0] k, input logic l);
    int n = 0;
    @(negedge clk);
    while (!word_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, word_valid, 1'b1);
    chk({tag, "_word"}, word_out, w);
    chk({tag, "_keep"}, word_keep, k);
    chk({tag, "_last"}, word_last, l);
    word_ready = 1'b1;
    @(posedge clk);
    #1 word_ready = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_word", word_out, 32'h0);
    chk("rst_keep", word_keep, 4'h0);
    chk("rst_last", word_last, 1'b0);
    chk("rst_cnt", upper_count, 4'h0);
    chk("rst_err", lower_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    put(8'h48, 0); put(8'h45, 0); put(8'h4C, 0); put(8'h4C, 0);
    get("hello0", 32'h4C4C4548, 4'hF, 1'b0);
    put(8'h4F, 1);
    get("hello1", 32'h0000004F, 4'h1, 1'b1);
    chk("hello_cnt", upper_count, 4'd5);
    chk("hello_cnt16", upper_count16, 16'd5);
    chk("hello_err", lower_err, 1'b0);
    do_reset();
    put(8'h41, 0); put(8'h42, 0); put(8'h43, 0); put(8'h44, 0);
    @(negedge clk);
    valid = 1'b1;
    din = 8'h45;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_word", word_out, 32'h44434241);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", word_valid, 1'b1);
    end
    chk("bp_cnt", upper_count, 4'd4);
    word_ready = 1'b1;
    @(posedge clk);
    #1 word_ready = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk("bp_rel_valid", word_valid, 1'b0);
    chk("bp_rel_in_ready", in_ready, 1'b1);
    chk("bp_rel_keep", word_keep, 4'h0);
    chk("bp_rel_cnt", upper_count, 4'd4);
    do_reset();
    put(8'h41, 0); put(8'h00, 0);
    get("nul", 32'h00000041, 4'h3, 1'b1);
    chk("nul_cnt", upper_count, 4'd1);
    do_reset();
    put(8'h61, 1);
    get("lower", 32'h00000061, 4'h1, 1'b1);
    chk("lower_err", lower_err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      put(8'h31, 1);
      get("lower_more", 32'h00000031, 4'h1, 1'b1);
    end
    chk("lower_err_sticky", lower_err, 1'b1);
    chk("lower_cnt", upper_count, 4'd0);
    do_reset();
    put(8'h5B, 0); put(8'h60, 0); put(8'h7B, 0); put(8'h40, 0);
    get("edge", 32'h407B605B, 4'hF, 1'b0);
    put(8'h80, 0); put(8'hFF, 1);
    get("high", 32'h0000FF80, 4'h3, 1'b1);
    chk("edge_cnt", upper_count, 4'd0);
    chk("edge_err", lower_err, 1'b0);
    do_reset();
    put(8'h41, 0); put(8'h42, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", in_ready, 1'b0);
    chk("mid_word", word_out, 32'h0);
    chk("mid_keep", word_keep, 4'h0);
    chk("mid_valid", word_valid, 1'b0);
    chk("mid_last", word_last, 1'b0);
    chk("mid_cnt", upper_count, 4'd0);
    chk("mid_err", lower_err, 1'b0);
    rst_n = 1'b1;
    put(8'h43, 1);
    get("mid", 32'h00000043, 4'h1, 1'b1);
    chk("mid_cnt_after", upper_count, 4'd1);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      put(8'h5A, i == 19);
      if (i % 4 == 3) get("sat", 32'h5A5A5A5A, 4'hF, i == 19);
    end
    chk("sat_cnt", upper_count, 4'd15);
    chk("sat_cnt16", upper_count16, 16'd20);
    @(negedge clk);
    chk("sat_no_extra", word_valid, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascii_word_packer.md
# ascii_word_packer

Streaming packer that sits directly downstream of the toUpper conversion stage. It accepts one converted ASCII byte per cycle over a valid/ready handshake and packs bytes little-endian into 32-bit words with a byte-keep mask and end-of-string marker. It counts uppercase letters and flags any lowercase letter that reached it, which indicates a conversion fault upstream. Its output feeds the word-wide text buffer.

## Interface
- CNT_W, 16, width of `upper_count`; the counter saturates at 2^CNT_W−1.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- ascii_in  in  8  converted character byte from the toUpper stage.
- in_valid  in  1  `ascii_in`/`in_last` valid.
- in_last  in  1  byte is the final byte of the current string.
- in_ready  out  1  packer can accept a byte this cycle.
- word_out  out  32  packed word; the first byte of the word is in [7:0].
- word_keep  out  4  bit i=1 means lane i (bits 8i+7:8i) holds a valid byte.
- word_last  out  1  word closes a string.
- word_valid  out  1  word outputs valid.
- word_ready  in  1  downstream accepts the word.
- upper_count  out  CNT_W  count of accepted bytes in 0x41–0x5A, saturating.
- lower_err  out  1  sticky flag; set when an accepted byte is in 0x61–0x7A.

## Operation
- Byte accept: `in_valid && in_ready` at a rising edge.
- FSM states:
  - **FILL**: `in_ready`=1 while `rst_n`=1.
    - Each accepted byte is written to lane `idx`, sets `keep[idx]`, and increments `idx` (2 bits).
    - Transition to **HOLD** if `idx`==3 at accept, if `in_last`=1, or if `ascii_in`==0x00. In the two string-closing cases, set `word_last`=1.
  - **HOLD**: `word_valid`=1 and `in_ready`=0.
    - On `word_ready`=1, transition to **FILL** and clear the data lanes, `keep`, `last`, and `idx`.
- No bypass. `in_ready` stays 0 for the whole HOLD cycle, including the cycle in which `word_ready` is sampled high.
- NUL (0x00) terminates the string. It is stored in its lane with its keep bit set, exactly like a byte with `in_last`=1.
- `in_last` and NUL on the same byte behave the same as either one alone.
- A string of exactly 4·k bytes: the k-th word carries `keep`=0xF and `word_last`=1. No empty word follows.
- Unused lanes in a partial word read 0x00.
- Counter and flag:
  - `upper_count` increments on every accepted byte in 0x41–0x5A and holds once it reaches all-ones.
  - `lower_err` is set by any accepted byte in 0x61–0x7A and clears only on reset.
  - Neither affects packing.
- `ascii_in` is not checked for bit 7. Bytes 0x80–0xFF are packed as data.

## Timing
- Reset (`rst_n`=0 at an edge) forces the following values; `in_ready`=0 combinationally while `rst_n`=0:
  - state = FILL, `idx`=0
  - `word_out`=0, `word_keep`=0, `word_last`=0, `word_valid`=0
  - `upper_count`=0, `lower_err`=0
- Reset mid-operation discards a partial or held word. After release, the next accepted byte goes to lane 0.
- Latency: `word_valid` rises on the edge at which the closing byte is accepted, so it is visible in the following cycle.
- Throughput: a full word needs 4 accept cycles + 1 HOLD cycle = 4 bytes per 5 cycles at best.
- While `word_valid`=1 and `word_ready`=0, `word_out`, `word_keep`, and `word_last` stay stable.
- `word_valid` falls on the edge at which `word_ready`=1 is sampled.
- `in_ready` depends only on state and `rst_n`. It has no combinational path from `word_ready` or `in_valid`.
- `word_ready` is ignored in FILL.

## Test plan
- **String "HELLO"**
  - Stimulus: bytes 0x48 0x45 0x4C 0x4C 0x4F, `in_last` on 0x4F, `word_ready`=1.
  - Required: word 0x4C4C4548 with keep 0xF, last 0; then word 0x0000004F with keep 0x1, last 1; `upper_count`=5; `lower_err`=0.
- **Backpressure**
  - Stimulus: fill a word with "ABCD", then hold `word_ready`=0 for 10 cycles.
  - Required: `word_out`=0x44434241 stable throughout; `in_ready`=0; no byte accepted while `in_valid` is held high.
  - Then raise `word_ready` for 1 cycle. Required: the next cycle shows `word_valid`=0 and `in_ready`=1.
- **NUL terminator**
  - Stimulus: bytes 0x41 0x00 with `in_last`=0.
  - Required: word 0x00000041, keep 0x3, last 1; `upper_count`=1.
- **Lowercase leak**
  - Stimulus: byte 0x61 with `in_last`=1.
  - Required: `lower_err`=1 and it remains 1 after 3 more words; `upper_count` unchanged; word 0x00000061 with keep 0x1.
- **Reset mid-fill**
  - Stimulus: accept 0x41 0x42, assert `rst_n`=0 for 1 edge, then send 0x43 with `in_last`.
  - Required: all outputs 0 after the reset edge; then word 0x00000043 with keep 0x1, last 1; `upper_count`=1.
- **Saturation and exact boundary** (with CNT_W=4)
  - Stimulus: 20 bytes of 0x5A with `in_last` on the 20th.
  - Required: `upper_count`=15; five words of 0x5A5A5A5A with keep 0xF; only the fifth has `word_last`=1.
